// File: rtl/bcd_clock_display_scan.sv
// Six-digit multiplexed 7-segment driver for the 12-hour BCD clock (HH MM SS).
// Inputs are snapshotted once per scan frame so a frame never shows two different times.
module bcd_clock_display_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       sec_tick,
   input  logic       pm,
   input  logic [7:0] hh,
   input  logic [7:0] mm,
   input  logic [7:0] ss,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       colon
);

   localparam int             CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK   = CNT_W'(BLANK_CYCLES);

   // Active-low segments {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'h40;
         4'd1:    seg_decode = 7'h79;
         4'd2:    seg_decode = 7'h24;
         4'd3:    seg_decode = 7'h30;
         4'd4:    seg_decode = 7'h19;
         4'd5:    seg_decode = 7'h12;
         4'd6:    seg_decode = 7'h02;
         4'd7:    seg_decode = 7'h78;
         4'd8:    seg_decode = 7'h00;
         4'd9:    seg_decode = 7'h10;
         default: seg_decode = 7'h3F;
      endcase
   endfunction

   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             snap_pm_q;
   logic [7:0]       snap_hh_q, snap_mm_q, snap_ss_q;
   logic             colon_state_q;
   logic             snap_load;
   logic [3:0]       digit;
   logic [5:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d, colon_d;

   always_comb begin
      scan_cnt_d = '0;
      idx_d      = 3'd0;
      if (en) begin
         if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
         end else begin
            scan_cnt_d = scan_cnt_q + CNT_W'(1);
            idx_d      = idx_q;
         end
      end

      snap_load = (scan_cnt_q == '0) && (idx_q == 3'd0);

      case (idx_q)
         3'd0:    digit = snap_ss_q[3:0];
         3'd1:    digit = snap_ss_q[7:4];
         3'd2:    digit = snap_mm_q[3:0];
         3'd3:    digit = snap_mm_q[7:4];
         3'd4:    digit = snap_hh_q[3:0];
         3'd5:    digit = snap_hh_q[7:4];
         default: digit = snap_ss_q[3:0];
      endcase

      // Pins are registered from the present scan state, giving one cycle of latency.
      an_d    = 6'h3F;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      colon_d = 1'b0;
      if (en) begin
         if (scan_cnt_q >= BLANK)
            an_d = ~(6'b1 << idx_q);
         if ((idx_q == 3'd5) && (digit == 4'd0))
            seg_d = 7'h7F;
         else
            seg_d = seg_decode(digit);
         dp_d    = ~((idx_q == 3'd0) && snap_pm_q);
         colon_d = colon_state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_q    <= '0;
         idx_q         <= 3'd0;
         snap_pm_q     <= 1'b0;
         snap_hh_q     <= 8'h00;
         snap_mm_q     <= 8'h00;
         snap_ss_q     <= 8'h00;
         colon_state_q <= 1'b1;
         an            <= 6'h3F;
         seg           <= 7'h7F;
         dp            <= 1'b1;
         colon         <= 1'b0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         if (snap_load) begin
            snap_pm_q <= pm;
            snap_hh_q <= hh;
            snap_mm_q <= mm;
            snap_ss_q <= ss;
         end
         if (sec_tick)
            colon_state_q <= ~colon_state_q;
         an    <= an_d;
         seg   <= seg_d;
         dp    <= dp_d;
         colon <= colon_d;
      end
   end

endmodule

// File: doc/bcd_clock_display_scan.md
Name: bcd_clock_display_scan

Overview:
- Downstream consumer of the 12-hour BCD time-of-day counter. Takes its hh/mm/ss/pm outputs and its 1 Hz enable pulse.
- Drives a six-digit, common-anode, time-multiplexed 7-segment display (HH MM SS) plus a separate colon LED. PM is shown on the rightmost decimal point.
- Inputs are snapshotted once per scan frame, so a display frame never mixes two different times (no tearing).

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is selected; legal range 2..2^20.
- BLANK_CYCLES, 1, cycles at the start of each digit slot with all anodes off (anti-ghosting); legal range 1..SCAN_DIV-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 = display dark
- sec_tick  in  1  one-cycle pulse, same pulse that advances the seconds counter
- pm  in  1  PM flag from time counter
- hh  in  8  hours, packed BCD {tens,ones}, 01..12
- mm  in  8  minutes, packed BCD 00..59
- ss  in  8  seconds, packed BCD 00..59
- an  out  6  anode selects, active-low; an[0] = rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- colon  out  1  colon LED, active-high

Behaviour:
- Reset is synchronous, active-high on clk; all state and outputs are registered.
- Reset values:
  - scan_cnt=0, idx=0, snapshot={pm,hh,mm,ss}=0, colon_state=1
  - an=6'h3F, seg=7'h7F, dp=1, colon=0
- Scan counter and digit index (while en=1):
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0→1→…→5→0.
  - Frame = 6*SCAN_DIV cycles.
- Snapshot:
  - {pm,hh,mm,ss} is loaded in every cycle where scan_cnt==0 and idx==0.
  - This includes the first cycle after reset and every cycle while en=0, since the counters are held at 0.
- Digit map:
  - idx0 = ss[3:0], idx1 = ss[7:4]
  - idx2 = mm[3:0], idx3 = mm[7:4]
  - idx4 = hh[3:0], idx5 = hh[7:4]
  - All digits are taken from the snapshot.
- Output latency: pins are registered from the current (scan_cnt, idx, snapshot), so they reflect the previous cycle's state (1-cycle latency).
- Anodes:
  - an = all-ones while scan_cnt < BLANK_CYCLES.
  - Otherwise an = ~(6'b1 << idx).
- Segment decode, 0–9:
  - 0 → 40, 1 → 79, 2 → 24, 3 → 30, 4 → 19
  - 5 → 12, 6 → 02, 7 → 78, 8 → 00, 9 → 10 (hex)
  - Nibble > 9 shows dash (seg=7'h3F).
- Leading-zero blanking: idx5 with snapshot hh tens == 0 → seg=7'h7F; the anode still follows normal scanning.
- Decimal point: dp=0 only when idx==0 and snapshot pm==1; otherwise 1. dp is not forced high during the blank window (anodes are off anyway).
- Colon:
  - colon_state toggles on every sec_tick, independent of en.
  - colon = colon_state & en.
- en=0:
  - scan_cnt and idx are forced to 0.
  - an=3F, seg=7F, dp=1, colon=0.
  - On en rising, scanning restarts at idx0 with a fresh snapshot.
- Simultaneous events:
  - reset beats en and sec_tick.
  - A sec_tick in the snapshot cycle does not affect the snapshot; it uses input values in that cycle.
- Reset mid-frame: immediately returns to reset values, and the next frame starts at idx0.
- Input changes mid-frame are not visible until the next snapshot.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1, frame=24 cycles):
1. Reset, then en=1, hh=8'h12, mm=8'h34, ss=8'h56, pm=1. Over one frame, the non-blank slots show:
   - an=3E seg=02 dp=0
   - an=3D seg=12
   - an=3B seg=19
   - an=37 seg=30
   - an=2F seg=24
   - an=1F seg=79
   - an=3F for exactly 1 cycle per slot.
2. hh=8'h09, mm=8'h05, ss=8'h00, pm=0:
   - idx5 slot: an=1F, seg=7F (leading zero blanked).
   - idx4 shows seg=10; dp stays 1 throughout.
3. Change ss from 8'h56 to 8'h57 at cycle 10 of a frame: the rest of that frame still shows 6; the next frame shows 7 (seg=78).
4. Drive ss=8'h5A: the idx0 slot shows seg=3F (dash); the other digits are unaffected.
5. Pulse sec_tick 3 times with en=1: colon goes 1→0→1→0. Then drop en: outputs go dark (an=3F, seg=7F, dp=1, colon=0) in the next cycle.
6. Assert reset at cycle 15 of a frame: outputs are at reset values the next cycle. After release, idx0 is selected after the blank cycle, with a snapshot taken on the first post-reset cycle.
